// File: rtl/multi_xfer_sequencer.sv
// multi_xfer_sequencer: walks a register mask and moves one word per set bit between RF and memory
module multi_xfer_sequencer #(
  parameter int NREG = 8,
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int ADDR_STEP = 1,
  localparam int RAW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            proc_rst,
  input  logic            start,
  input  logic            mode,
  input  logic [NREG-1:0] mask,
  input  logic [AW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   xfer_count,
  output logic [AW-1:0]   end_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic [RAW-1:0]  rf_raddr,
  input  logic [DW-1:0]   rf_rdata,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [DW-1:0]   rf_wdata
);
  typedef enum logic [2:0] {IDLE, SCAN, REQ, WB, DONE} state_t;
  state_t state, state_nx;
  logic mode_r;
  logic [NREG-1:0] mask_r;
  logic [AW-1:0] addr_r;
  logic [RAW-1:0] idx, low_idx;
  logic [CW-1:0] count;
  logic [DW-1:0] rdata_r;
  logic advance;
  always_comb begin
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (mask_r[i]) low_idx = RAW'(i);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? SCAN : IDLE;
      SCAN:    state_nx = (mask_r == '0) ? DONE : REQ;
      REQ:     state_nx = !mem_ack ? REQ : mode_r ? SCAN : WB;
      WB:      state_nx = SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // idx is still the lowest set bit here, so m & (m-1) retires exactly mask[idx]
  assign advance = (state == REQ && mem_ack && mode_r) || state == WB;
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      mask_r  <= '0;
      addr_r  <= '0;
      idx     <= '0;
      count   <= '0;
      rdata_r <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mode_r <= mode;
        mask_r <= mask;
        addr_r <= base_addr;
        count  <= '0;
      end
      if (state == SCAN) idx <= low_idx;
      if (state == REQ && mem_ack && !mode_r) rdata_r <= mem_rdata;
      if (advance) begin
        mask_r <= mask_r & (mask_r - NREG'(1));
        addr_r <= addr_r + AW'(ADDR_STEP);
        count  <= count + CW'(1);
      end
    end
  end
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign mem_req    = state == REQ;
  assign mem_we     = mem_req & mode_r;
  assign mem_addr   = mem_req ? addr_r : '0;
  assign mem_wdata  = mem_req ? rf_rdata : '0;
  assign rf_raddr   = idx;
  assign rf_we      = state == WB;
  assign rf_waddr   = rf_we ? idx : '0;
  assign rf_wdata   = rf_we ? rdata_r : '0;
  assign xfer_count = count;
  assign end_addr   = addr_r;
endmodule

// File: tb/tb_multi_xfer_sequencer.sv
// tb_multi_xfer_sequencer: directed checks of the LM/SM engine at 8x16/16 and 16x16/12
module tb_multi_xfer_sequencer;
  logic clk = 0;
  logic proc_rst = 0;
  always #5 clk = ~clk;
  logic start = 0, mode = 0, sel = 0, spur = 0, rf_init = 0, clr = 0;
  logic [15:0] mask = 0, base = 0;
  int delay = 0, wcnt = 0, checks = 0, failures = 0;
  logic a_busy, a_done, a_mem_req, a_mem_we, a_rf_we;
  logic [3:0] a_cnt;
  logic [15:0] a_end, a_maddr, a_wdata, a_rfwd;
  logic [2:0] a_rra, a_rwa;
  logic b_busy, b_done, b_mem_req, b_mem_we, b_rf_we;
  logic [4:0] b_cnt;
  logic [11:0] b_end, b_maddr;
  logic [15:0] b_wdata, b_rfwd;
  logic [3:0] b_rra, b_rwa;
  logic busy, done, mem_req, mem_we, mem_ack, rf_we;
  logic [4:0] cnt;
  logic [15:0] end_addr, mem_addr, mem_wdata, rf_wdata, mem_rdata;
  logic [3:0] rf_waddr;
  logic [15:0] rf [16];
  logic [32:0] log_q [$];
  logic overlap = 0, unstable = 0, req_seen = 0, hold = 0;
  logic [33:0] prev = 0;
  assign busy      = sel ? b_busy : a_busy;
  assign done      = sel ? b_done : a_done;
  assign mem_req   = sel ? b_mem_req : a_mem_req;
  assign mem_we    = sel ? b_mem_we : a_mem_we;
  assign rf_we     = sel ? b_rf_we : a_rf_we;
  assign cnt       = sel ? b_cnt : {1'b0, a_cnt};
  assign end_addr  = sel ? {4'h0, b_end} : a_end;
  assign mem_addr  = sel ? {4'h0, b_maddr} : a_maddr;
  assign mem_wdata = sel ? b_wdata : a_wdata;
  assign rf_wdata  = sel ? b_rfwd : a_rfwd;
  assign rf_waddr  = sel ? b_rwa : {1'b0, a_rwa};
  assign mem_rdata = mem_req ? (mem_addr ^ 16'hBEEF) : 16'hDEAD;
  assign mem_ack   = (mem_req && wcnt == delay) || spur;
  multi_xfer_sequencer dut_a (
    .clk(clk), .proc_rst(proc_rst), .start(start && !sel), .mode(mode), .mask(mask[7:0]),
    .base_addr(base), .busy(a_busy), .done(a_done), .xfer_count(a_cnt), .end_addr(a_end),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_maddr), .mem_wdata(a_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack && !sel), .rf_raddr(a_rra), .rf_rdata(rf[{1'b0, a_rra}]),
    .rf_we(a_rf_we), .rf_waddr(a_rwa), .rf_wdata(a_rfwd)
  );
  multi_xfer_sequencer #(.NREG(16), .AW(12)) dut_b (
    .clk(clk), .proc_rst(proc_rst), .start(start && sel), .mode(mode), .mask(mask),
    .base_addr(base[11:0]), .busy(b_busy), .done(b_done), .xfer_count(b_cnt), .end_addr(b_end),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_maddr), .mem_wdata(b_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack && sel), .rf_raddr(b_rra), .rf_rdata(rf[b_rra]),
    .rf_we(b_rf_we), .rf_waddr(b_rwa), .rf_wdata(b_rfwd)
  );
  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (rf_init) for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 + 16'(i);
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (clr) begin
      log_q.delete();
      overlap <= 0;
      unstable <= 0;
      req_seen <= 0;
    end else begin
      if (mem_req && mem_ack) log_q.push_back({mem_we, mem_addr, mem_wdata});
      if (mem_req && rf_we) overlap <= 1;
      if (mem_req) req_seen <= 1;
      if (hold && {mem_req, mem_we, mem_addr, mem_wdata} != prev) unstable <= 1;
    end
    hold <= mem_req && !mem_ack;
    prev <= {mem_req, mem_we, mem_addr, mem_wdata};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic prep();
    @(negedge clk);
    clr = 1;
    rf_init = 1;
    @(negedge clk);
    clr = 0;
    rf_init = 0;
  endtask
  task automatic run(input logic m, input logic [15:0] mk, input logic [15:0] b, input int d,
                     input bit glitch, output int cyc, output logic [4:0] rc, output logic [15:0] re);
    @(negedge clk);
    delay = d;
    mode = m;
    mask = mk;
    base = b;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 3) begin
        start = 1;
        mode = ~m;
        mask = 16'hFFFF;
        base = 16'h0999;
      end
      if (glitch && cyc == 4) start = 0;
    end
    check("done_seen", 32'(done), 1);
    rc = cnt;
    re = end_addr;
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("busy_drop", 32'(busy), 0);
  endtask
  task automatic suite();
    int hi, n, cyc;
    logic [15:0] amax, all;
    logic [4:0] rc;
    logic [15:0] re;
    hi = sel ? 15 : 7;
    n = hi + 1;
    amax = sel ? 16'h0FFF : 16'hFFFF;
    all = sel ? 16'hFFFF : 16'h00FF;
    prep();
    run(0, 16'(1 << hi) | 16'h0005, 16'h0040, 0, 0, cyc, rc, re);
    check("t1_cycles", cyc, 11);
    check("t1_count", 32'(rc), 3);
    check("t1_end", 32'(re), 16'h0043);
    check("t1_r0", 32'(rf[0]), 16'h0040 ^ 16'hBEEF);
    check("t1_r2", 32'(rf[2]), 16'h0041 ^ 16'hBEEF);
    check("t1_rhi", 32'(rf[hi]), 16'h0042 ^ 16'hBEEF);
    check("t1_r1_kept", 32'(rf[1]), 16'h1001);
    check("t1_nreq", log_q.size(), 3);
    check("t1_overlap", 32'(overlap), 0);
    prep();
    run(1, all, 16'h0010, 2, 0, cyc, rc, re);
    check("t2_cycles", cyc, 4 * n + 2);
    check("t2_count", 32'(rc), n);
    check("t2_end", 32'(re), 16'h0010 + n);
    check("t2_nreq", log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check("t2_we", 32'(log_q[i][32]), 1);
      check("t2_addr", 32'(log_q[i][31:16]), 16'h0010 + i);
      check("t2_data", 32'(log_q[i][15:0]), 16'h1000 + i);
    end
    check("t2_stable", 32'(unstable), 0);
    check("t2_overlap", 32'(overlap), 0);
    prep();
    run(0, 16'h0000, 16'h0123, 0, 0, cyc, rc, re);
    check("t3_cycles", cyc, 2);
    check("t3_count", 32'(rc), 0);
    check("t3_end", 32'(re), 16'h0123);
    check("t3_noreq", 32'(req_seen), 0);
    prep();
    run(1, 16'(3 << (hi - 1)), amax, 0, 0, cyc, rc, re);
    check("t4_cycles", cyc, 6);
    check("t4_count", 32'(rc), 2);
    check("t4_end", 32'(re), 16'h0001);
    check("t4_nreq", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_addr0", 32'(log_q[0][31:16]), 32'(amax));
      check("t4_data0", 32'(log_q[0][15:0]), 16'h1000 + hi - 1);
      check("t4_addr1", 32'(log_q[1][31:16]), 0);
      check("t4_data1", 32'(log_q[1][15:0]), 16'h1000 + hi);
    end
  endtask
  initial begin
    int cyc;
    logic [4:0] rc;
    logic [15:0] re;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_busy | b_busy), 0);
    check("rst_done", 32'(a_done | b_done), 0);
    check("rst_req", 32'(a_mem_req | b_mem_req), 0);
    check("rst_rfwe", 32'(a_rf_we | b_rf_we), 0);
    check("rst_count", 32'(a_cnt) | 32'(b_cnt), 0);
    check("rst_end", 32'(a_end) | 32'(b_end), 0);
    check("rst_maddr", 32'(a_maddr) | 32'(b_maddr), 0);
    proc_rst = 1;
    sel = 0;
    suite();
    prep();
    @(negedge clk);
    mode = 0;
    mask = 16'h000F;
    base = 16'h0030;
    delay = 6;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 100 && !(mem_req && mem_addr == 16'h0031); k++) @(negedge clk);
    check("t5_reach_req2", 32'(mem_req && mem_addr == 16'h0031), 1);
    @(negedge clk);
    #2 proc_rst = 0;
    #1;
    check("t5_req_drop", 32'(mem_req), 0);
    check("t5_busy_drop", 32'(busy), 0);
    check("t5_rfwe", 32'(rf_we), 0);
    check("t5_count", 32'(cnt), 0);
    check("t5_end", 32'(end_addr), 0);
    repeat (2) @(negedge clk);
    proc_rst = 1;
    check("t5_r0", 32'(rf[0]), 16'h0030 ^ 16'hBEEF);
    check("t5_r1_kept", 32'(rf[1]), 16'h1001);
    run(0, 16'h0002, 16'h0050, 0, 0, cyc, rc, re);
    check("t5_rerun_cycles", cyc, 5);
    check("t5_rerun_r1", 32'(rf[1]), 16'h0050 ^ 16'hBEEF);
    check("t5_rerun_count", 32'(rc), 1);
    check("t5_rerun_end", 32'(re), 16'h0051);
    prep();
    @(negedge clk);
    spur = 1;
    repeat (3) @(negedge clk);
    check("t6_spur_busy", 32'(busy), 0);
    check("t6_spur_count", 32'(cnt), 1);
    check("t6_spur_rfwe", 32'(rf_we), 0);
    spur = 0;
    run(1, 16'h0003, 16'h0020, 0, 1, cyc, rc, re);
    check("t6_cycles", cyc, 6);
    check("t6_count", 32'(rc), 2);
    check("t6_end", 32'(re), 16'h0022);
    check("t6_nreq", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t6_addr0", 32'(log_q[0][31:16]), 16'h0020);
      check("t6_data1", 32'(log_q[1][15:0]), 16'h1001);
    end
    sel = 1;
    suite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
